// File: rtl/mult_div_if.sv
// Handshake and result bundle between the control unit and mult_div_unit.
//   master: control side. It drives the start requests, signedness and operands,
//           and receives the results and status.
//   slave : mult_div_unit side. It receives the requests and drives hi/lo, busy
//           and the done/zero status pulses.
interface mult_div_if #(
  parameter int WIDTH = 32
);
  logic             start_mult;
  logic             start_div;
  logic             signed_op;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             mult_done;
  logic             div_done;
  logic             div_zero;

  modport master (
    output start_mult, start_div, signed_op, op_a, op_b,
    input  hi, lo, busy, mult_done, div_done, div_zero
  );

  modport slave (
    input  start_mult, start_div, signed_op, op_a, op_b,
    output hi, lo, busy, mult_done, div_done, div_zero
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit that feeds the HI/LO registers. Each operation
// resolves one bit per clock.
//   clk, reset_in : clock and synchronous active-high reset
//   bus (slave)   : start_mult/start_div/signed_op/op_a/op_b in;
//                   hi/lo results, busy, and the mult_done/div_done/div_zero
//                   pulses out
// Multiply  : shift-add on a 2*WIDTH accumulator, with {hi,lo} = product.
// Divide    : restoring division, with lo = quotient and hi = remainder.
// Signed operations run on magnitudes. The result signs are restored in FIX.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset_in,
  mult_div_if.slave   bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               is_div;
  logic               neg_q;      // product or quotient must be negated
  logic               neg_r;      // remainder must be negated
  logic [WIDTH-1:0]   mcand;      // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc;        // product accumulator, or {unused, dividend/quotient}
  logic [WIDTH:0]     rem;        // partial remainder

  logic [WIDTH-1:0]   hi_r, lo_r;
  logic               mult_done_r, div_done_r, div_zero_r;

  logic signed [WIDTH-1:0] a_s, b_s;
  logic               a_neg, b_neg;
  logic               go_mult, go_div, go_zero;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] prod_fix;

  function automatic logic [WIDTH-1:0] negate_w(input logic [WIDTH-1:0] v);
    return ~v + WIDTH'(1);
  endfunction

  function automatic logic [2*WIDTH-1:0] negate_2w(input logic [2*WIDTH-1:0] v);
    return ~v + (2*WIDTH)'(1);
  endfunction

  // The magnitude of the most-negative value keeps the same bit pattern. That
  // pattern is the correct unsigned magnitude 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? negate_w(v) : v;
  endfunction

  assign a_s   = bus.op_a;
  assign b_s   = bus.op_b;
  assign a_neg = bus.signed_op && (a_s < 0);
  assign b_neg = bus.signed_op && (b_s < 0);

  // Multiply has priority over divide. All requests are ignored while busy.
  assign go_mult = (state == IDLE) && bus.start_mult;
  assign go_div  = (state == IDLE) && !bus.start_mult && bus.start_div && (bus.op_b != '0);
  assign go_zero = (state == IDLE) && !bus.start_mult && bus.start_div && (bus.op_b == '0);

  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    div_shift = {rem[WIDTH-1:0], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mcand};
    prod_fix  = neg_q ? negate_2w(acc) : acc;
  end

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (reset_in) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (go_mult || go_div) state_nxt = RUN;
      RUN:  if (cnt == CNT_W'(1))  state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- control and result registers ----
  always_ff @(posedge clk) begin
    if (reset_in) begin
      cnt         <= '0;
      hi_r        <= '0;
      lo_r        <= '0;
      mult_done_r <= 1'b0;
      div_done_r  <= 1'b0;
      div_zero_r  <= 1'b0;
    end else begin
      mult_done_r <= 1'b0;
      div_done_r  <= 1'b0;
      div_zero_r  <= 1'b0;
      case (state)
        IDLE: begin
          if (go_mult || go_div) cnt <= CNT_W'(WIDTH);
          if (go_zero) begin
            div_done_r <= 1'b1;
            div_zero_r <= 1'b1;
          end
        end
        RUN: cnt <= cnt - CNT_W'(1);
        FIX: begin
          if (is_div) begin
            lo_r       <= neg_q ? negate_w(acc[WIDTH-1:0]) : acc[WIDTH-1:0];
            hi_r       <= neg_r ? negate_w(rem[WIDTH-1:0]) : rem[WIDTH-1:0];
            div_done_r <= 1'b1;
          end else begin
            hi_r        <= prod_fix[2*WIDTH-1:WIDTH];
            lo_r        <= prod_fix[WIDTH-1:0];
            mult_done_r <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // ---- iteration datapath ----
  always_ff @(posedge clk) begin
    if (go_mult) begin
      is_div <= 1'b0;
      neg_q  <= a_neg ^ b_neg;
      neg_r  <= 1'b0;
      mcand  <= magnitude(bus.op_a, a_neg);
      acc    <= {{WIDTH{1'b0}}, magnitude(bus.op_b, b_neg)};
      rem    <= '0;
    end else if (go_div) begin
      is_div <= 1'b1;
      neg_q  <= a_neg ^ b_neg;
      neg_r  <= a_neg;
      mcand  <= magnitude(bus.op_b, b_neg);
      acc    <= {{WIDTH{1'b0}}, magnitude(bus.op_a, a_neg)};
      rem    <= '0;
    end else if (state == RUN) begin
      if (!is_div) begin
        acc <= {mul_sum, acc[WIDTH-1:1]};
      end else begin
        // Restore the remainder when the trial subtraction goes negative.
        rem <= div_diff[WIDTH] ? div_shift : div_diff;
        acc <= {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], ~div_diff[WIDTH]};
      end
    end
  end

  assign bus.hi        = hi_r;
  assign bus.lo        = lo_r;
  assign bus.busy      = (state != IDLE);
  assign bus.mult_done = mult_done_r;
  assign bus.div_done  = div_done_r;
  assign bus.div_zero  = div_zero_r;

endmodule
